// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending constants, dispenser states and coin-type encoding
package vend_pkg;

    localparam int UNIT_5  = 1;
    localparam int UNIT_10 = 2;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        WAIT_ACK,
        DONE,
        FAULT
    } disp_state_e;

    // Encoding shared with the vending machine's change code: value is the coin worth in 5-unit units.
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_e;

    function automatic int coin_units(coin_e c);
        case (c)
            COIN_5:  return UNIT_5;
            COIN_10: return UNIT_10;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_inventory.sv
// rtl/change_inventory.sv - saturating 5-unit and 10-unit coin inventory counters
module change_inventory #(
    parameter int INV_W   = 6,
    parameter int INIT_5  = 8,
    parameter int INIT_10 = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill_5,
    input  logic             refill_10,
    input  logic             dec_5,
    input  logic             dec_10,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_10
);

    logic [INV_W-1:0] inv_5_q, inv_5_d;
    logic [INV_W-1:0] inv_10_q, inv_10_d;

    // Simultaneous refill and decrement cancel out, which also keeps a full counter full.
    function automatic logic [INV_W-1:0] step(input logic [INV_W-1:0] cnt,
                                              input logic inc, input logic dec);
        if (inc && !dec && cnt != {INV_W{1'b1}})
            return cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    always_comb begin
        inv_5_d  = step(inv_5_q, refill_5, dec_5);
        inv_10_d = step(inv_10_q, refill_10, dec_10);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_5_q  <= INV_W'(INIT_5);
            inv_10_q <= INV_W'(INIT_10);
        end else begin
            inv_5_q  <= inv_5_d;
            inv_10_q <= inv_10_d;
        end
    end

    assign inv_5  = inv_5_q;
    assign inv_10 = inv_10_q;

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin-at-a-time change payout FSM driving the hopper
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int INV_W       = 6,
    parameter int INIT_5      = 8,
    parameter int INIT_10     = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             coin_ack,
    output logic             eject_5,
    output logic             eject_10,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill_5,
    input  logic             refill_10,
    output logic [INV_W-1:0] inv_5,
    output logic [INV_W-1:0] inv_10
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    disp_state_e      state_q, state_d;
    coin_e            coin_q, coin_d;
    logic [AMT_W-1:0] bal_q, bal_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ack_take;

    assign ack_take = (state_q == WAIT_ACK) && coin_ack;

    change_inventory #(
        .INV_W  (INV_W),
        .INIT_5 (INIT_5),
        .INIT_10(INIT_10)
    ) u_inventory (
        .clk      (clk),
        .reset    (reset),
        .refill_5 (refill_5),
        .refill_10(refill_10),
        .dec_5    (ack_take && coin_q == COIN_5),
        .dec_10   (ack_take && coin_q == COIN_10),
        .inv_5    (inv_5),
        .inv_10   (inv_10)
    );

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        bal_d   = bal_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bal_d   = req_amount;
                    rem_d   = '0;
                    state_d = (req_amount == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                // Never overpay: a single owed unit needs a 5-coin even when 10s are stocked.
                if (bal_q >= AMT_W'(UNIT_10) && inv_10 != '0) begin
                    coin_d  = COIN_10;
                    state_d = EJECT;
                end else if (bal_q >= AMT_W'(UNIT_5) && inv_5 != '0) begin
                    coin_d  = COIN_5;
                    state_d = EJECT;
                end else begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    bal_d   = bal_q - AMT_W'(coin_units(coin_q));
                    state_d = (bal_d == '0) ? DONE : SELECT;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            FAULT: begin
                rem_d   = bal_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            coin_q  <= COIN_NONE;
            bal_q   <= '0;
            rem_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            bal_q   <= bal_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign eject_5   = (state_q == EJECT) && (coin_q == COIN_5);
    assign eject_10  = (state_q == EJECT) && (coin_q == COIN_10);
    assign done      = (state_q == DONE);
    assign error     = (state_q == FAULT);
    assign remaining = rem_q;

endmodule
